// File: rtl/div_pkg.sv
// div_pkg: shared FSM type and latency constants for seq_restoring_divider.
// Optional feature macro used by the divider: DIV_SIGNED_EN.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_state_t;

   // Accept edge to out_valid when the divisor is zero.
   localparam int DIV_ZERO_LATENCY = 1;

   // Accept edge to out_valid for a normal division of width n.
   function automatic int div_latency(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shift in a dividend bit and
// conditionally subtract the divisor using an invert + carry-in adder.
module div_step
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N:0]   r_i,
   input  logic         bit_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   r_o,
   output logic         q_o
);

   logic [N+1:0] shifted;
   logic [N+1:0] dvs_inv;
   logic [N+1:0] diff;
   logic         borrow;

   // Subtract mode: add inverted divisor plus one; a set top bit means
   // the trial went negative, so the partial remainder is restored.
   assign shifted = {r_i, bit_i};
   assign dvs_inv = ~{2'b00, divisor_i};
   assign diff    = shifted + dvs_inv + {{(N+1){1'b0}}, 1'b1};
   assign borrow  = diff[N+1];

   assign r_o = borrow ? shifted[N:0] : diff[N:0];
   assign q_o = ~borrow;

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-bit multi-cycle divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [N-1:0]  ZERO     = '0;

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    r_q, r_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [N-1:0]  dq_q, dq_d;
   logic [N-1:0]  dsr_q, dsr_d;
   logic          dbz_q, dbz_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          zero_q, zero_d;

   logic          accept;
   logic [N:0]    r_step;
   logic          q_bit;
   logic [N-1:0]  a_mag;
   logic [N-1:0]  b_mag;
   logic [N-1:0]  q_res;
   logic [N-1:0]  r_src;
   logic [N-1:0]  r_res;

   assign accept = in_valid && (state_q == IDLE);

   // On divide-by-zero the untouched dividend is the remainder.
   assign r_src = dbz_q ? dq_q : r_q[N-1:0];

`ifdef DIV_SIGNED_EN
   logic sq_q, sq_d;
   logic sr_q, sr_d;

   assign a_mag = dividend[N-1] ? (ZERO - dividend) : dividend;
   assign b_mag = divisor[N-1]  ? (ZERO - divisor)  : divisor;
   assign q_res = sq_q ? (ZERO - dq_q)  : dq_q;
   assign r_res = sr_q ? (ZERO - r_src) : r_src;

   // Result signs captured with the operands: quotient by sign mismatch,
   // remainder follows the dividend.
   always_comb begin
      sq_d = sq_q;
      sr_d = sr_q;
      if (accept) begin
         sq_d = dividend[N-1] ^ divisor[N-1];
         sr_d = dividend[N-1];
      end
   end

   // Sign flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= 1'b0;
         sr_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
         sr_q <= sr_d;
      end
   end
`else
   assign a_mag = dividend;
   assign b_mag = divisor;
   assign q_res = dq_q;
   assign r_res = r_src;
`endif

   div_step #(
      .N(N)
   ) u_step (
      .r_i      (r_q),
      .bit_i    (dq_q[N-1]),
      .divisor_i(dsr_q),
      .r_o      (r_step),
      .q_o      (q_bit)
   );

   // Next-state and datapath control for IDLE / BUSY / DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      dq_d    = dq_q;
      dsr_d   = dsr_q;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               cnt_d   = '0;
               r_d     = '0;
               dq_d    = a_mag;
               dsr_d   = b_mag;
               dbz_d   = (divisor == ZERO);
            end
         end
         BUSY: begin
            if (dbz_q || (cnt_q == CNT_LAST)) begin
               state_d = DONE;
               quot_d  = dbz_q ? {N{1'b1}} : q_res;
               rem_d   = r_res;
               zero_d  = dbz_q;
            end else begin
               r_d   = r_step;
               dq_d  = {dq_q[N-2:0], q_bit};
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               quot_d  = '0;
               rem_d   = '0;
               zero_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, working and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         dq_q    <= '0;
         dsr_q   <= '0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         dq_q    <= dq_d;
         dsr_q   <= dsr_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = zero_q;

endmodule
